// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end control of the multi-cycle CPU.
// Holds the 5-phase one-hot phase ring, the instruction register and the
// program counter. Every output is a plain register output.
module fetch_sequencer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ir_wdata,
    input  logic [WIDTH-1:0] pc_load,
    input  logic             pc_load_en,
    input  logic             pc_hold,
    input  logic             halt,
    output logic [4:0]       phase,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] pc,
    output logic             halted
);

    localparam logic [4:0] P1 = 5'b00001;
    localparam logic [4:0] P2 = 5'b00010;
    localparam logic [4:0] P3 = 5'b00100;
    localparam logic [4:0] P4 = 5'b01000;
    localparam logic [4:0] P5 = 5'b10000;

    logic [4:0]       phase_reg, phase_next;
    logic [WIDTH-1:0] ir_reg, ir_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             halted_reg;

    // Phase ring: advance one step per unhalted edge; any corrupted
    // (non-one-hot) value is steered back to P1.
    always_comb begin
        phase_next = phase_reg;
        if (!halt) begin
            case (phase_reg)
                P1:      phase_next = P2;
                P2:      phase_next = P3;
                P3:      phase_next = P4;
                P4:      phase_next = P5;
                P5:      phase_next = P1;
                default: phase_next = P1;
            endcase
        end
    end

    // Instruction capture happens only on the edge that ends P1.
    always_comb begin
        ir_next = ir_reg;
        if (!halt && (phase_reg == P1))
            ir_next = ir_wdata;
    end

    // PC: increment at the end of P1 (unless held), branch at the end of P5.
    // The increment wraps naturally at the register width.
    always_comb begin
        pc_next = pc_reg;
        if (!halt) begin
            if ((phase_reg == P1) && !pc_hold)
                pc_next = pc_reg + 1'b1;
            else if ((phase_reg == P5) && pc_load_en)
                pc_next = pc_load;
        end
    end

    // State registers with immediate (asynchronous) reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_reg  <= P1;
            ir_reg     <= '0;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            ir_reg     <= ir_next;
            pc_reg     <= pc_next;
            halted_reg <= halt;
        end
    end

    assign phase  = phase_reg;
    assign ir     = ir_reg;
    assign pc     = pc_reg;
    assign halted = halted_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// traffic, all checked against a step-count based reference model.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] ir_wdata;
    logic [15:0] pc_load;
    logic        pc_load_en;
    logic        pc_hold;
    logic        halt;
    logic [4:0]  phase;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction step 0..4, plus architectural state.
    int          m_step;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_halted;

    fetch_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .ir_wdata   (ir_wdata),
        .pc_load    (pc_load),
        .pc_load_en (pc_load_en),
        .pc_hold    (pc_hold),
        .halt       (halt),
        .phase      (phase),
        .ir         (ir),
        .pc         (pc),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_step   = 0;
        m_pc     = 16'h0000;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
    endtask

    // One rising edge as seen by the model, using the inputs present at that edge.
    task automatic model_edge();
        if (halt) begin
            m_halted = 1'b1;
        end else begin
            m_halted = 1'b0;
            if (m_step == 0) begin
                m_ir = ir_wdata;
                if (!pc_hold) m_pc = m_pc + 16'd1;
            end else if (m_step == 4 && pc_load_en) begin
                m_pc = pc_load;
            end
            m_step = (m_step + 1) % 5;
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] exp_phase;
        exp_phase = 5'b00001 << m_step;
        chk({tag, ".phase"},  {27'd0, phase},  {27'd0, exp_phase});
        chk({tag, ".ir"},     {16'd0, ir},     {16'd0, m_ir});
        chk({tag, ".pc"},     {16'd0, pc},     {16'd0, m_pc});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        $display("tick %s: phase=%b ir=%h pc=%h halted=%b", tag, phase, ir, pc, halted);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        halt       = 1'b0;
        pc_load_en = 1'b0;
        pc_hold    = 1'b0;
    endtask

    // Run unhalted edges until the model sits at the requested step.
    task automatic advance_to(input int target);
        idle_inputs();
        for (int i = 0; i < 5 && m_step != target; i++)
            tick("adv");
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        $display("async reset %s: phase=%b ir=%h pc=%h halted=%b", tag, phase, ir, pc, halted);
        check_all(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        ir_wdata   = 16'h0000;
        pc_load    = 16'h0000;
        idle_inputs();
        model_reset();
        #7;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: one instruction from reset
        ir_wdata = 16'hC105;
        tick("t1.p1");
        chk("t1.ir_c105", {16'd0, ir}, 32'h0000C105);
        chk("t1.pc_0001", {16'd0, pc}, 32'h00000001);
        for (int i = 0; i < 4; i++) begin
            ir_wdata = 16'($urandom);
            tick("t1.pn");
        end
        chk("t1.back_p1", {27'd0, phase}, 32'h00000001);

        // 2: three instructions, ir_wdata scrambled outside P1
        for (int n = 0; n < 3; n++) begin
            ir_wdata = 16'($urandom);
            tick("t2.p1");
            for (int i = 0; i < 4; i++) begin
                ir_wdata = 16'($urandom);
                tick("t2.pn");
            end
        end

        // 3: branch at P5, pc_load_en in P3 ignored
        advance_to(4);
        pc_load    = 16'h0040;
        pc_load_en = 1'b1;
        tick("t3.br");
        chk("t3.pc_0040", {16'd0, pc}, 32'h00000040);
        pc_load_en = 1'b0;
        tick("t3.p1");
        chk("t3.pc_0041", {16'd0, pc}, 32'h00000041);
        tick("t3.p2");
        pc_load    = 16'h1234;
        pc_load_en = 1'b1;
        tick("t3.p3en");
        chk("t3.p3_noload", {16'd0, pc}, 32'h00000041);
        pc_load_en = 1'b0;

        // 4: wrap and hold
        advance_to(4);
        pc_load    = 16'hFFFF;
        pc_load_en = 1'b1;
        tick("t4.ld");
        pc_load_en = 1'b0;
        tick("t4.wrap");
        chk("t4.pc_0000", {16'd0, pc}, 32'h00000000);
        advance_to(4);
        pc_load_en = 1'b1;
        tick("t4.ld2");
        pc_load_en = 1'b0;
        pc_hold    = 1'b1;
        ir_wdata   = 16'h5A5A;
        tick("t4.hold");
        chk("t4.pc_ffff", {16'd0, pc}, 32'h0000FFFF);
        chk("t4.ir_5a5a", {16'd0, ir}, 32'h00005A5A);
        pc_hold = 1'b0;

        // 5: halt in P3, then async reset mid-P4
        advance_to(2);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ir_wdata = 16'($urandom);
            tick("t5.halt");
            chk("t5.phase_p3", {27'd0, phase}, 32'h00000004);
            chk("t5.halted", {31'd0, halted}, 32'h00000001);
        end
        halt = 1'b0;
        tick("t5.rel");
        chk("t5.phase_p4", {27'd0, phase}, 32'h00000008);
        async_reset("t5.rst");
        chk("t5.rst_pc", {16'd0, pc}, 32'h00000000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ir_wdata   = 16'($urandom);
            pc_load    = 16'($urandom);
            pc_load_en = 1'($urandom_range(0, 1));
            pc_hold    = ($urandom_range(0, 3) == 0);
            halt       = ($urandom_range(0, 3) == 0);
            tick("rnd");
            if ($urandom_range(0, 49) == 0) begin
                idle_inputs();
                async_reset("rnd.rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
